// File: rtl/plc_io_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plc_io_scan_ctrl_pkg
//  Purpose  : Shared types, FSM state codes and width helpers for the
//             PLC digital I/O scan-cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package plc_io_scan_ctrl_pkg;

  // Scan FSM state type and codes (3-bit, fixed encoding for legacy tools)
  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_APPLY   = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_SAMPLE  = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // APPLY + SAMPLE + CAPTURE + DONE, excluding any settle cycles
  localparam int SCAN_FIXED_CYC = 4;

  // Shortest possible scan, start request to DONE
  function automatic int scan_len_min(input int settle_cyc);
    return SCAN_FIXED_CYC + settle_cyc;
  endfunction

  // Bits needed for a counter running 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/plc_io_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : plc_io_scan_ctrl_if
//  Purpose  : CPU-side control/image signals and digital_io channel signals
//             of the scan sequencer. master = CPU / I/O top, slave = sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface plc_io_scan_ctrl_if #(
  parameter int N_CH = 8
);
  // CPU side
  logic            scan_start;
  logic            auto_en;
  logic [N_CH-1:0] dir_cfg;
  logic [N_CH-1:0] out_image;
  logic            fault_clr;
  logic [N_CH-1:0] in_image;
  logic [N_CH-1:0] fault;
  logic            scan_busy;
  logic            scan_done;
  // digital_io side
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] ch_dir;
  logic [N_CH-1:0] ch_data_in;
  logic [N_CH-1:0] ch_data_out;

  modport master (
    output scan_start, auto_en, dir_cfg, out_image, fault_clr, ch_data_out,
    input  in_image, fault, scan_busy, scan_done, ch_en, ch_dir, ch_data_in
  );

  modport slave (
    input  scan_start, auto_en, dir_cfg, out_image, fault_clr, ch_data_out,
    output in_image, fault, scan_busy, scan_done, ch_en, ch_dir, ch_data_in
  );

endinterface

`default_nettype wire

// File: rtl/plc_io_scan_ctrl_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : plc_io_scan_ctrl_scan_timer
//  Purpose  : Loadable down-counter with zero flag. Load has priority over
//             decrement; decrement stops at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module plc_io_scan_ctrl_scan_timer #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, count down, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/plc_io_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : plc_io_scan_ctrl
//  Purpose  : Scan-cycle sequencer for N_CH digital_io channels. Applies the
//             output image and directions, settles, samples the pins into the
//             input image and flags output channels with bad readback.
//  Revision : 1.0 - initial release
// ============================================================================
module plc_io_scan_ctrl
  import plc_io_scan_ctrl_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int SETTLE_CYC = 2,
  parameter int PERIOD_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  plc_io_scan_ctrl_if.slave    bus
);

  localparam int                c_per_w      = cnt_width(PERIOD_CYC);
  localparam logic [c_per_w-1:0] c_per_reload = c_per_w'(PERIOD_CYC - 1);

  state_t          state_q;
  state_t          state_d;
  logic [N_CH-1:0] shadow_dir_q;
  logic [N_CH-1:0] shadow_out_q;
  logic [N_CH-1:0] ch_dir_q;
  logic [N_CH-1:0] ch_data_in_q;
  logic [N_CH-1:0] in_image_q;
  logic [N_CH-1:0] fault_q;
  logic [N_CH-1:0] fault_d;

  logic            w_per_zero;
  logic            w_settle_done;
  logic            w_trigger;
  logic            w_launch;
  logic            w_capture;
  logic [N_CH-1:0] w_mismatch;

  // The auto period counter runs downward: PERIOD_CYC-1 here corresponds to
  // an elapsed count of 0, so zero marks the last cycle of each period.
  plc_io_scan_ctrl_scan_timer #(
    .W       (c_per_w),
    .RST_VAL (c_per_reload)
  ) u_period_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (!bus.auto_en || w_per_zero),
    .load_val_i (c_per_reload),
    .dec_i      (bus.auto_en),
    .zero_o     (w_per_zero)
  );

  if (SETTLE_CYC > 0) begin : g_settle
    localparam int                c_set_w      = cnt_width(SETTLE_CYC);
    localparam logic [c_set_w-1:0] c_set_reload = c_set_w'(SETTLE_CYC - 1);

    // Loaded in APPLY so the first SETTLE cycle sees SETTLE_CYC-1
    plc_io_scan_ctrl_scan_timer #(
      .W       (c_set_w),
      .RST_VAL ('0)
    ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (state_q == ST_APPLY),
      .load_val_i (c_set_reload),
      .dec_i      (state_q == ST_SETTLE),
      .zero_o     (w_settle_done)
    );
  end else begin : g_no_settle
    assign w_settle_done = 1'b1;
  end

  assign w_trigger  = bus.scan_start | (bus.auto_en & w_per_zero);
  assign w_launch   = (state_q == ST_IDLE) & w_trigger;
  assign w_capture  = (state_q == ST_CAPTURE);
  assign w_mismatch = shadow_dir_q & (bus.ch_data_out ^ shadow_out_q);

  // Scan sequence next-state; triggers outside IDLE are simply ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (w_trigger) state_d = ST_APPLY;
      ST_APPLY:   state_d = (SETTLE_CYC > 0) ? ST_SETTLE : ST_SAMPLE;
      ST_SETTLE:  if (w_settle_done) state_d = ST_SAMPLE;
      ST_SAMPLE:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Sticky fault: a clear drops old bits, but a bit set by this capture survives
  always_comb begin
    fault_d = bus.fault_clr ? '0 : fault_q;
    if (w_capture) begin
      fault_d = fault_d | w_mismatch;
    end
  end

  // State, shadow, channel drive and image registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shadow_dir_q <= '0;
      shadow_out_q <= '0;
      ch_dir_q     <= '0;
      ch_data_in_q <= '0;
      in_image_q   <= '0;
      fault_q      <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      // Snapshot and drive values land together on the edge into APPLY, so
      // the channels see the new image for the whole APPLY enable pulse and
      // mid-scan CPU writes cannot reach the pins until the next scan.
      if (w_launch) begin
        shadow_dir_q <= bus.dir_cfg;
        shadow_out_q <= bus.out_image;
        ch_dir_q     <= bus.dir_cfg;
        ch_data_in_q <= bus.out_image;
      end
      if (w_capture) begin
        in_image_q <= bus.ch_data_out;
      end
    end
  end

  assign bus.ch_en      = ((state_q == ST_APPLY) || (state_q == ST_SAMPLE)) ? {N_CH{1'b1}} : {N_CH{1'b0}};
  assign bus.ch_dir     = ch_dir_q;
  assign bus.ch_data_in = ch_data_in_q;
  assign bus.in_image   = in_image_q;
  assign bus.fault      = fault_q;
  assign bus.scan_busy  = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                          (state_q == ST_SAMPLE) || (state_q == ST_CAPTURE);
  assign bus.scan_done  = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_plc_io_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plc_io_scan_ctrl
//  Purpose  : Directed, table-driven bench for the scan sequencer with a
//             simple pin model (driven outputs, external inputs, forced pins).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_plc_io_scan_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  plc_io_scan_ctrl_if #(.N_CH(8)) bus ();

  plc_io_scan_ctrl #(
    .N_CH       (8),
    .SETTLE_CYC (2),
    .PERIOD_CYC (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Pin model: output channels show the driven level, input channels the
  // external level, and forced bits override either.
  logic [7:0] ext_pins = 8'h00;
  logic [7:0] frc_mask = 8'h00;
  logic [7:0] frc_val  = 8'h00;
  assign bus.ch_data_out = ((((bus.ch_dir & bus.ch_data_in) | (~bus.ch_dir & ext_pins)) & ~frc_mask)
                           | (frc_mask & frc_val));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] dir_cfg;
    logic [7:0] out_img;
    logic [7:0] ext;
    logic [7:0] fmask;
    logic [7:0] fval;
    logic [7:0] exp_in;
    logic [7:0] exp_fault;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pulse scan_start in IDLE, wait for scan_done (bounded), then step back to IDLE
  task automatic run_scan(output int lat);
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    lat = 1;
    while (!bus.scan_done && lat < 50) begin
      tick();
      lat++;
    end
    tick();
  endtask

  initial begin
    int lat;
    int n_done;
    int n_busy;
    int n_both;
    int dk [3];

    vecs[0] = '{8'hF0, 8'hA0, 8'h05, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{8'hF0, 8'hA0, 8'h05, 8'h80, 8'h00, 8'h25, 8'h80};
    vecs[2] = '{8'hF0, 8'hA0, 8'h05, 8'h00, 8'h00, 8'hA5, 8'h80};
    vecs[3] = '{8'hFF, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h80};
    vecs[4] = '{8'h00, 8'hFF, 8'h96, 8'h00, 8'h00, 8'h96, 8'h80};

    bus.scan_start = 1'b0;
    bus.auto_en    = 1'b0;
    bus.dir_cfg    = 8'h00;
    bus.out_image  = 8'h00;
    bus.fault_clr  = 1'b0;

    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_ch_dir",   bus.ch_dir,     0);
    chk("rst_ch_en",    bus.ch_en,      0);
    chk("rst_in_image", bus.in_image,   0);
    chk("rst_busy",     bus.scan_busy,  0);
    rst_n = 1'b1;
    tick();

    // Table of single scans
    for (int i = 0; i < 5; i++) begin
      bus.dir_cfg   = vecs[i].dir_cfg;
      bus.out_image = vecs[i].out_img;
      ext_pins      = vecs[i].ext;
      frc_mask      = vecs[i].fmask;
      frc_val       = vecs[i].fval;
      run_scan(lat);
      chk($sformatf("v%0d_latency", i),  lat,            6);
      chk($sformatf("v%0d_in_image", i), bus.in_image,   vecs[i].exp_in);
      chk($sformatf("v%0d_fault", i),    bus.fault,      vecs[i].exp_fault);
      chk($sformatf("v%0d_ch_dir", i),   bus.ch_dir,     vecs[i].dir_cfg);
      chk($sformatf("v%0d_ch_data", i),  bus.ch_data_in, vecs[i].out_img);
    end

    // fault_clr in the CAPTURE cycle: old bit 7 clears, new bit 6 is set
    bus.dir_cfg   = 8'hF0;
    bus.out_image = 8'h40;
    ext_pins      = 8'h05;
    frc_mask      = 8'h40;
    frc_val       = 8'h00;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    repeat (4) tick();
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("setwin_done",  bus.scan_done, 1);
    chk("setwin_fault", bus.fault,     8'h40);
    chk("setwin_in",    bus.in_image,  8'h05);
    tick();
    frc_mask = 8'h00;

    // scan_start held for 10 cycles: two scans, busy 5 cycles each
    n_done = 0; n_busy = 0; n_both = 0;
    bus.scan_start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 9) bus.scan_start = 1'b0;
      if (bus.scan_done) n_done++;
      if (bus.scan_busy) n_busy++;
      if (bus.scan_done && bus.scan_busy) n_both++;
    end
    chk("burst_dones",   n_done, 2);
    chk("burst_busy",    n_busy, 10);
    chk("burst_overlap", n_both, 0);
    chk("burst_fault",   bus.fault, 8'h40);

    // Auto scans every 20 cycles, then none once disabled
    n_done = 0;
    dk[0] = 0; dk[1] = 0; dk[2] = 0;
    bus.auto_en = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (bus.scan_done) begin
        if (n_done < 3) dk[n_done] = k;
        n_done++;
      end
    end
    chk("auto_count",  n_done, 3);
    chk("auto_first",  dk[0], 25);
    chk("auto_second", dk[1], 45);
    chk("auto_third",  dk[2], 65);
    bus.auto_en = 1'b0;
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.scan_done) n_done++;
    end
    chk("auto_off", n_done, 0);

    // Reset in SETTLE: everything drops immediately, no scan_done afterwards
    bus.dir_cfg   = 8'hFF;
    bus.out_image = 8'h5A;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    tick();
    chk("pre_rst_ch_dir", bus.ch_dir, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("async_ch_dir",   bus.ch_dir,     0);
    chk("async_ch_data",  bus.ch_data_in, 0);
    chk("async_in_image", bus.in_image,   0);
    chk("async_fault",    bus.fault,      0);
    chk("async_busy",     bus.scan_busy,  0);
    tick(); tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.scan_done) n_done++;
    end
    chk("post_rst_done",  n_done,     0);
    chk("post_rst_chdir", bus.ch_dir, 0);
    chk("post_rst_en",    bus.ch_en,  0);

    // CPU writes during SETTLE do not disturb the running scan
    bus.dir_cfg   = 8'hF0;
    bus.out_image = 8'hA0;
    ext_pins      = 8'h05;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    tick();
    bus.dir_cfg   = 8'h0F;
    bus.out_image = 8'h5F;
    tick();
    chk("midscan_ch_dir",  bus.ch_dir,     8'hF0);
    chk("midscan_ch_data", bus.ch_data_in, 8'hA0);
    lat = 3;
    while (!bus.scan_done && lat < 50) begin
      tick();
      lat++;
    end
    chk("midscan_latency", lat,          6);
    chk("midscan_in",      bus.in_image, 8'hA5);
    chk("midscan_ch_dir2", bus.ch_dir,   8'hF0);
    tick();
    run_scan(lat);
    chk("next_ch_dir",  bus.ch_dir,     8'h0F);
    chk("next_ch_data", bus.ch_data_in, 8'h5F);
    chk("next_in",      bus.in_image,   8'h0F);

    // Idle fault_clr wipes a freshly set fault
    frc_mask = 8'h01;
    frc_val  = 8'h00;
    run_scan(lat);
    chk("force0_fault", bus.fault,    8'h01);
    chk("force0_in",    bus.in_image, 8'h0E);
    frc_mask = 8'h00;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("idle_clr_fault", bus.fault, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
